// File: rtl/ped_req_pkg.sv
// Shared types and defaults for the pedestrian request conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ped_req_pkg;

    typedef enum logic [1:0] {
        PR_IDLE    = 2'd0,
        PR_REQ     = 2'd1,
        PR_HOLDOFF = 2'd2
    } ped_req_state_t;

    localparam int PR_DEBOUNCE_CYCLES_DEF = 16;
    localparam int PR_HOLDOFF_CYCLES_DEF  = 32;
    localparam int PR_CNT_W_DEF           = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability debounce for one asynchronous button input.
// Latency: din first sampled at edge N -> level changes after edge N+1+CYCLES; rise pulses in the following cycle.
// Backpressure: none; rise is a single-cycle event with no handshake.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   din    in   raw asynchronous input (active-high)
//   level  out  debounced level
//   rise   out  1-cycle pulse after level goes 0->1 (only once the input has been seen released)
module btn_debounce
    import ped_req_pkg::*;
#(
    parameter int CYCLES = PR_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW       = $clog2(CYCLES + 1);
    // Two extra low samples cover the synchroniser flops, which read 0 straight out of reset
    // regardless of the real input.
    localparam int ARM_CYCLES = CYCLES + 2;
    localparam int AW       = $clog2(ARM_CYCLES + 1);

    logic          sync_1;
    logic          sync_out;
    logic [CW-1:0] cnt;
    logic [AW-1:0] low_cnt;
    logic          armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1   <= 1'b0;
            sync_out <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
            low_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            sync_1   <= din;
            sync_out <= sync_1;
            rise     <= 1'b0;

            // Consecutive-mismatch counter; any agreeing cycle restarts the run.
            if (sync_out == level) begin
                cnt <= '0;
            end else if (cnt >= CW'(CYCLES - 1)) begin
                level <= sync_out;
                cnt   <= '0;
                rise  <= armed & sync_out;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A button held through reset would otherwise debounce up to 1 and look like a
            // fresh press. Rising edges only count after the input has been seen released.
            if (!armed) begin
                if (sync_out) begin
                    low_cnt <= '0;
                end else if (low_cnt >= AW'(ARM_CYCLES - 1)) begin
                    armed <= 1'b1;
                end else begin
                    low_cnt <= low_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ped_request_conditioner.sv
// Conditions a bouncing pedestrian push-button into a latched request level for the traffic-light controller.
// Latency: btn_raw first sampled at edge N -> btn_level after edge N+1+DEBOUNCE_CYCLES, ped_btn after edge N+2+DEBOUNCE_CYCLES.
// Backpressure: request is held until ped_ack; presses during REQ merge, presses during HOLDOFF are dropped.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_raw      in   raw pedestrian button (asynchronous, active-high, may bounce)
//   ped_ack      in   1-cycle grant pulse from the controller
//   ped_btn      out  latched request level
//   btn_level    out  debounced button level
//   holdoff      out  high while presses are being discarded after a grant
//   press_count  out  accepted-press count; built only when PED_REQ_COUNT_EN is defined, else tied to 0
module ped_request_conditioner
    import ped_req_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PR_DEBOUNCE_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES  = PR_HOLDOFF_CYCLES_DEF,
    parameter int CNT_W           = PR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_ack,
    output logic             ped_btn,
    output logic             btn_level,
    output logic             holdoff,
    output logic [CNT_W-1:0] press_count
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic           press;
    ped_req_state_t state;
    logic [HW-1:0]  hcnt;

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (btn_raw),
        .level (btn_level),
        .rise  (press)
    );

    // hcnt is loaded with HOLDOFF_CYCLES-1 and the exit happens on the cycle it reads 0,
    // giving exactly HOLDOFF_CYCLES cycles with holdoff high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= PR_IDLE;
            ped_btn <= 1'b0;
            holdoff <= 1'b0;
            hcnt    <= '0;
        end else begin
            case (state)
                PR_IDLE: begin
                    if (press) begin
                        state   <= PR_REQ;
                        ped_btn <= 1'b1;
                    end
                end
                PR_REQ: begin
                    // A press landing on the ack cycle is dropped: the grant wins.
                    if (ped_ack) begin
                        state   <= PR_HOLDOFF;
                        ped_btn <= 1'b0;
                        holdoff <= 1'b1;
                        hcnt    <= HW'(HOLDOFF_CYCLES - 1);
                    end
                end
                PR_HOLDOFF: begin
                    if (hcnt == '0) begin
                        state   <= PR_IDLE;
                        holdoff <= 1'b0;
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: begin
                    state   <= PR_IDLE;
                    ped_btn <= 1'b0;
                    holdoff <= 1'b0;
                end
            endcase
        end
    end

`ifdef PED_REQ_COUNT_EN
    logic [CNT_W-1:0] press_cnt;

    // Only IDLE->REQ transitions count; merged and discarded presses never reach here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt <= '0;
        end else if (state == PR_IDLE && press && press_cnt != '1) begin
            press_cnt <= press_cnt + 1'b1;
        end
    end

    assign press_count = press_cnt;
`else
    assign press_count = '0;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
module tb_ped_request_conditioner;

    localparam int D  = 4;
    localparam int H  = 8;
    localparam int CW = 2;
    localparam int HN = D + 3;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          btn_raw = 1'b0;
    logic          ped_ack = 1'b0;
    logic          ped_btn;
    logic          btn_level;
    logic          holdoff;
    logic [CW-1:0] press_count;

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLDOFF_CYCLES  (H),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .ped_ack     (ped_ack),
        .ped_btn     (ped_btn),
        .btn_level   (btn_level),
        .holdoff     (holdoff),
        .press_count (press_count)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected press_count for a given number of accepted presses.
    function automatic int exp_cnt(input int acc);
        int m;
        m = (1 << CW) - 1;
`ifndef PED_REQ_COUNT_EN
        m = 0;
`endif
        return (acc > m) ? m : acc;
    endfunction

    // Advance n rising edges, then settle on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int ep, input int el, input int eh, input int acc);
        check({tag, ".ped_btn"},     int'(ped_btn),     ep);
        check({tag, ".btn_level"},   int'(btn_level),   el);
        check({tag, ".holdoff"},     int'(holdoff),     eh);
        check({tag, ".press_count"}, int'(press_count), exp_cnt(acc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        btn_raw = 1'b0;
        ped_ack = 1'b0;
        #1;
        check_out("reset", 0, 0, 0, 0);
        cyc(2);
        reset = 1'b1;
    endtask

    // Press, get granted, release, and sit out the holdoff.
    task automatic full_press(input string tag, input int acc);
        btn_raw = 1'b1;
        cyc(D + 3);
        check({tag, ".ped_btn"},     int'(ped_btn),     1);
        check({tag, ".press_count"}, int'(press_count), exp_cnt(acc));
        btn_raw = 1'b0;
        cyc(D + 2);
        check({tag, ".level_low"}, int'(btn_level), 0);
        ped_ack = 1'b1;
        cyc(1);
        ped_ack = 1'b0;
        check({tag, ".holdoff_on"}, int'(holdoff), 1);
        cyc(H);
        check({tag, ".holdoff_off"}, int'(holdoff), 0);
        check({tag, ".ped_idle"},    int'(ped_btn), 0);
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the button sample from the previous edge, hist[1] the one before (what the
    // synchroniser presents now). -1 marks pre-reset history: it neither changes the
    // debounced level nor counts as a released button.
    int m_hist[HN];
    int m_lvl, m_armed, m_rise, m_req, m_hold, m_acc;

    task automatic model_reset();
        m_hist[0] = 0;
        m_hist[1] = 0;
        for (int i = 2; i < HN; i++) m_hist[i] = -1;
        m_lvl = 0; m_armed = 0; m_rise = 0; m_req = 0; m_hold = 0; m_acc = 0;
    endtask

    task automatic model_step(input int b, input int a);
        bit all_diff, all_low, new_rise;
        if (m_req != 0) begin
            if (a != 0) begin
                m_req  = 0;
                m_hold = H;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_rise != 0) begin
            m_req = 1;
            m_acc++;
        end
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
            if (m_hist[1 + j] < 0 || m_hist[1 + j] == m_lvl) all_diff = 1'b0;
        all_low = 1'b1;
        for (int j = 0; j < D + 2; j++)
            if (m_hist[1 + j] != 0) all_low = 1'b0;
        new_rise = all_diff && (m_lvl == 0) && (m_armed != 0);
        if (all_diff) m_lvl = 1 - m_lvl;
        if (all_low) m_armed = 1;
        m_rise = new_rise ? 1 : 0;
        for (int i = HN - 1; i > 0; i--) m_hist[i] = m_hist[i - 1];
        m_hist[0] = b;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic btn;
        logic ack;
        int   n;
        int   e_ped;
        int   e_lvl;
        int   e_hold;
        int   e_acc;
    } vec_t;

    vec_t tab[22];

    initial begin
        int   run_left;
        logic cur;

        tab[0]  = '{1'b0, 1'b0, 9,  0, 0, 0, 0};  // idle after reset
        tab[1]  = '{1'b1, 1'b0, 5,  0, 0, 0, 0};  // edges 10..14: not yet debounced
        tab[2]  = '{1'b1, 1'b0, 1,  0, 1, 0, 0};  // edge 15: btn_level up
        tab[3]  = '{1'b1, 1'b0, 1,  1, 1, 0, 1};  // edge 16: ped_btn up
        tab[4]  = '{1'b1, 1'b0, 3,  1, 1, 0, 1};
        tab[5]  = '{1'b1, 1'b1, 1,  0, 1, 1, 1};  // edge 20: ack
        tab[6]  = '{1'b1, 1'b0, 7,  0, 1, 1, 1};  // edge 27: still holdoff
        tab[7]  = '{1'b1, 1'b0, 1,  0, 1, 0, 1};  // edge 28: holdoff ends
        tab[8]  = '{1'b1, 1'b0, 10, 0, 1, 0, 1};  // still held: no new request
        tab[9]  = '{1'b0, 1'b0, 8,  0, 0, 0, 1};  // release
        tab[10] = '{1'b1, 1'b0, 1,  0, 0, 0, 1};  // bounce 1,0,1,0
        tab[11] = '{1'b0, 1'b0, 1,  0, 0, 0, 1};
        tab[12] = '{1'b1, 1'b0, 1,  0, 0, 0, 1};
        tab[13] = '{1'b0, 1'b0, 1,  0, 0, 0, 1};
        tab[14] = '{1'b0, 1'b0, 8,  0, 0, 0, 1};
        tab[15] = '{1'b1, 1'b0, 3,  0, 0, 0, 1};  // 3-cycle glitch
        tab[16] = '{1'b0, 1'b0, 8,  0, 0, 0, 1};
        tab[17] = '{1'b1, 1'b0, 6,  0, 1, 0, 1};  // clean press, level edge
        tab[18] = '{1'b1, 1'b0, 1,  1, 1, 0, 2};  // request one cycle later
        tab[19] = '{1'b0, 1'b0, 6,  1, 0, 0, 2};  // release keeps request
        tab[20] = '{1'b0, 1'b1, 1,  0, 0, 1, 2};
        tab[21] = '{1'b0, 1'b0, 8,  0, 0, 0, 2};

        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out("por", 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            btn_raw = tab[i].btn;
            ped_ack = tab[i].ack;
            cyc(tab[i].n);
            check_out($sformatf("tab[%0d]", i), tab[i].e_ped, tab[i].e_lvl, tab[i].e_hold, tab[i].e_acc);
        end
        ped_ack = 1'b0;

        // Counter: five accepted presses from a cleared count.
        do_reset();
        cyc(D + 4);
        for (int i = 0; i < 5; i++) full_press($sformatf("cnt%0d", i), i + 1);

        // Merge: second press during REQ adds nothing.
        do_reset();
        cyc(D + 4);
        btn_raw = 1'b1; cyc(D + 3);
        check_out("merge.first", 1, 1, 0, 1);
        btn_raw = 1'b0; cyc(D + 2);
        btn_raw = 1'b1; cyc(D + 3);
        check_out("merge.second", 1, 1, 0, 1);
        btn_raw = 1'b0; cyc(D + 2);
        ped_ack = 1'b1; cyc(1); ped_ack = 1'b0;
        cyc(H);
        check_out("merge.done", 0, 0, 0, 1);

        // Collision: rise and ack on the same edge.
        btn_raw = 1'b1; cyc(D + 3);
        check_out("coll.req", 1, 1, 0, 2);
        btn_raw = 1'b0; cyc(D + 2);
        btn_raw = 1'b1; cyc(D + 2);
        check_out("coll.pre", 1, 1, 0, 2);
        ped_ack = 1'b1; cyc(1); ped_ack = 1'b0;
        check_out("coll.ack", 0, 1, 1, 2);
        cyc(H - 1);
        check_out("coll.hold", 0, 1, 1, 2);
        cyc(1);
        check_out("coll.end", 0, 1, 0, 2);
        cyc(10);
        check_out("coll.held", 0, 1, 0, 2);
        btn_raw = 1'b0; cyc(D + 4);

        // Re-press entirely inside holdoff is discarded; same press afterwards is taken.
        btn_raw = 1'b1; cyc(D + 3);
        check_out("hold.req", 1, 1, 0, 3);
        btn_raw = 1'b0; cyc(D + 2);
        ped_ack = 1'b1; cyc(1); ped_ack = 1'b0;
        btn_raw = 1'b1; cyc(5);
        btn_raw = 1'b0; cyc(1);
        check_out("hold.inside", 0, 1, 1, 3);
        cyc(10);
        check_out("hold.after", 0, 0, 0, 3);
        btn_raw = 1'b1; cyc(D + 3);
        check_out("hold.repress", 1, 1, 0, 4);

        // Asynchronous reset pulse while requesting, button still held.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        #2 reset = 1'b1;
        @(negedge clk);
        cyc(20);
        check_out("rst.held", 0, 1, 0, 0);
        btn_raw = 1'b0; cyc(12);
        check_out("rst.release", 0, 0, 0, 0);
        btn_raw = 1'b1; cyc(D + 3);
        check_out("rst.repress", 1, 1, 0, 1);

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        run_left = 0;
        cur = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd.ped_btn",     int'(ped_btn),     m_req);
            check("rnd.btn_level",   int'(btn_level),   m_lvl);
            check("rnd.holdoff",     int'(holdoff),     (m_hold > 0) ? 1 : 0);
            check("rnd.press_count", int'(press_count), exp_cnt(m_acc));
            if (run_left == 0) begin
                if ($urandom_range(0, 3) == 0) run_left = $urandom_range(1, 3);
                else                           run_left = $urandom_range(5, 20);
                cur = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            end
            run_left--;
            btn_raw = cur;
            ped_ack = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            model_step(int'(btn_raw), int'(ped_ack));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
